// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: converter FSM states,
// BCD digit width and the ALU control encodings used by the sequencer.
package calc_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    FINISH  = 2'd2
  } state_t;

  localparam logic [2:0] CTRL_ADD = 3'b000;
  localparam logic [2:0] CTRL_SUB = 3'b001;

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more, so
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import calc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= BCD_DIGIT_W'(5)) begin
      o_digit = i_digit + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter: signed ALU result to sign + packed BCD,
// one magnitude bit per clock, results held until the next conversion ends.
module result_bcd_converter
  import calc_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int DIGITS = 10
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          START,
  input  logic [IN_W-1:0]               VALUE,
  input  logic                          NEG_IN,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          SIGN,
  output logic [BCD_DIGIT_W*DIGITS-1:0] BCD,
  output logic                          OVERFLOW,
  output state_t                        o_dbg_state
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;

  // Handshake: START is accepted only in IDLE (VALUE/NEG_IN sampled on that
  // edge); BUSY is high for the IN_W shift cycles; DONE pulses for one cycle
  // when BCD/SIGN/OVERFLOW update, and those outputs then hold.

  state_t             r_state;
  state_t             w_next_state;
  logic [BCD_W-1:0]   r_work;
  logic [BCD_W-1:0]   w_adj;
  logic [IN_W-1:0]    r_mag;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign_lat;
  logic               r_ovf_acc;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_sign;
  logic               r_ovf;
  logic               r_done;
  logic               w_last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit(r_work[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit(w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign w_last = (r_cnt == CNT_W'(1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (START) w_next_state = CONVERT;
      CONVERT: if (w_last) w_next_state = FINISH;
      FINISH:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    BUSY        = (r_state == CONVERT);
    DONE        = r_done;
    SIGN        = r_sign;
    BCD         = r_bcd;
    OVERFLOW    = r_ovf;
    o_dbg_state = r_state;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_work     <= '0;
      r_mag      <= '0;
      r_cnt      <= '0;
      r_sign_lat <= 1'b0;
      r_ovf_acc  <= 1'b0;
      r_bcd      <= '0;
      r_sign     <= 1'b0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == FINISH);
      case (r_state)
        IDLE: begin
          if (START) begin
            r_sign_lat <= NEG_IN;
            // The most negative input negates to itself, which read as
            // unsigned is exactly the required magnitude 2^(IN_W-1).
            r_mag      <= NEG_IN ? (~VALUE + IN_W'(1)) : VALUE;
            r_work     <= '0;
            r_ovf_acc  <= 1'b0;
            r_cnt      <= CNT_W'(IN_W);
          end
        end
        CONVERT: begin
          r_work    <= {w_adj[BCD_W-2:0], r_mag[IN_W-1]};
          r_mag     <= {r_mag[IN_W-2:0], 1'b0};
          r_ovf_acc <= r_ovf_acc | w_adj[BCD_W-1];
          r_cnt     <= r_cnt - CNT_W'(1);
        end
        FINISH: begin
          r_bcd  <= r_work;
          r_sign <= r_sign_lat;
          r_ovf  <= r_ovf_acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Bench for result_bcd_converter: a 10-digit and a 3-digit instance share
// stimulus and are checked against decimal arithmetic on the true magnitude.
module tb_result_bcd_converter;
  import calc_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic        NEG_IN;
  logic [31:0] VALUE;

  logic        busy, done, sign, ovf;
  logic [39:0] bcd;
  state_t      st;
  logic        busy3, done3, sign3, ovf3;
  logic [11:0] bcd3;
  state_t      st3;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  result_bcd_converter #(.IN_W(32), .DIGITS(10)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .VALUE(VALUE), .NEG_IN(NEG_IN),
    .BUSY(busy), .DONE(done), .SIGN(sign), .BCD(bcd), .OVERFLOW(ovf),
    .o_dbg_state(st)
  );

  result_bcd_converter #(.IN_W(32), .DIGITS(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .START(START), .VALUE(VALUE), .NEG_IN(NEG_IN),
    .BUSY(busy3), .DONE(done3), .SIGN(sign3), .BCD(bcd3), .OVERFLOW(ovf3),
    .o_dbg_state(st3)
  );

  function automatic longint ref_mag(input logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    return (s < 0) ? -s : s;
  endfunction

  function automatic logic [39:0] ref_bcd(input longint m);
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Called one time unit after a rising edge; returns one unit after edge 0.
  task automatic start_conv(input logic [31:0] v);
    if (v == 32'd0 && v[31]) $display("illegal stimulus: NEG_IN=1 with VALUE=0");
    START = 1'b1; VALUE = v; NEG_IN = v[31];
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < 100 && !ok) begin
      if (done) ok = 1'b1;
      else begin
        @(posedge CLK); #1;
        n++;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; START = 1'b0; VALUE = '0; NEG_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    vectors++;
    if ({busy, done, sign, ovf, bcd} !== 44'd0) begin
      miscompares++;
      $display("FAIL reset10: got %h required 0", {busy, done, sign, ovf, bcd});
    end
    vectors++;
    if ({busy3, done3, sign3, ovf3, bcd3} !== 16'd0) begin
      miscompares++;
      $display("FAIL reset3: got %h required 0", {busy3, done3, sign3, ovf3, bcd3});
    end
    RESET = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic check_conv(input logic [31:0] v, input int exp_n, input string tag);
    int n; bit ok;
    longint m;
    logic [39:0] e;
    logic [11:0] e3;
    bit o3;
    m = ref_mag(v); e = ref_bcd(m); e3 = e[11:0]; o3 = (m > 999);
    wait_done(n, ok);
    vectors++;
    if (!ok || n != exp_n) begin
      miscompares++;
      $display("FAIL %s latency: got done=%0d after %0d edges required %0d", tag, ok, n, exp_n);
    end
    vectors++;
    if ({bcd, sign, ovf, busy} !== {e, v[31], 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s v=%h: got bcd=%h sign=%b ovf=%b busy=%b required bcd=%h sign=%b ovf=0 busy=0",
               tag, v, bcd, sign, ovf, busy, e, v[31]);
    end
    vectors++;
    if (done3 !== 1'b1 || ovf3 !== o3 || sign3 !== v[31] || (!o3 && bcd3 !== e3)) begin
      miscompares++;
      $display("FAIL %s small v=%h: got done=%b bcd=%h sign=%b ovf=%b required bcd=%h sign=%b ovf=%b",
               tag, v, done3, bcd3, sign3, ovf3, e3, v[31], o3);
    end
  endtask

  task automatic test_directed();
    logic [31:0] tbl [9];
    tbl = '{32'd1023, 32'hFFFFFC00, 32'h80000000, 32'h7FFFFFFF, 32'd999,
            32'd0, 32'd1000, 32'd9, 32'hFFFFFFFF};
    foreach (tbl[i]) begin
      start_conv(tbl[i]);
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL directed busy: got busy=%b done=%b required busy=1 done=0", busy, done);
      end
      check_conv(tbl[i], 33, "directed");
    end
  endtask

  task automatic test_ignore_busy();
    int pulses;
    start_conv(32'd5);
    repeat (9) begin @(posedge CLK); #1; end
    START = 1'b1; VALUE = 32'd7; NEG_IN = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0;
    check_conv(32'd5, 23, "ignore");
    pulses = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (done) pulses++;
    end
    vectors++;
    if (pulses != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore extra: got %0d extra DONE busy=%b required 0 and 0", pulses, busy);
    end
    start_conv(32'd7);
    check_conv(32'd7, 33, "after_ignore");
  endtask

  task automatic test_reset_abort();
    int pulses;
    start_conv(32'hFFFFFC00);
    check_conv(32'hFFFFFC00, 33, "pre_abort");
    start_conv(32'h00012345);
    repeat (15) begin @(posedge CLK); #1; end
    vectors++;
    if ({bcd, sign, busy} !== {40'h0000001024, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL hold: got bcd=%h sign=%b busy=%b required 1024 1 1", bcd, sign, busy);
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    vectors++;
    if ({busy, done, sign, ovf, bcd} !== 44'd0) begin
      miscompares++;
      $display("FAIL abort: got %h required 0", {busy, done, sign, ovf, bcd});
    end
    pulses = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (done) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL abort done: got %0d pulses required 0", pulses);
    end
    start_conv(32'd0);
    check_conv(32'd0, 33, "post_abort");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    a = $urandom(); b = $urandom_range(0, 99999);
    start_conv(a);
    check_conv(a, 33, "b2b_first");
    start_conv(b);
    check_conv(b, 33, "b2b_second");
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int i = 0; i < 40; i++) begin
      case (i % 4)
        0: v = $urandom();
        1: v = 32'($urandom_range(0, 2000));
        2: v = -32'($urandom_range(1, 2000));
        default: v = $urandom_range(0, 1) ? 32'h80000000 + 32'($urandom_range(0, 15))
                                          : 32'h7FFFFFFF - 32'($urandom_range(0, 15));
      endcase
      start_conv(v);
      check_conv(v, 33, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_busy();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
